// File: rtl/bf_net_sched.sv
// bf_net_sched: sequencer for the two-butterfly, four-lane coefficient datapath.
// Issues coefficient word reads stage by stage for NTT / INTT / PWM, drives the
// output-network mode and lane routing selects, and replays the read strobe and
// address through a 15-deep delay line as the write-back strobe and address.
// Optional feature macro: BF_NET_SCHED_STALL_EN (adds a stall input that
// freezes issue and drain while keeping the write-back delay line moving).
module bf_net_sched #(
   parameter int LAT_BF  = 7,
   parameter int LAT_PWM = 10,
   parameter int AW      = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [1:0]    mode,
`ifdef BF_NET_SCHED_STALL_EN
   input  logic          stall,
`endif
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [2:0]    net_sel,
   output logic [1:0]    sel_a_0,
   output logic [1:0]    sel_a_1,
   output logic [1:0]    sel_a_2,
   output logic [1:0]    sel_a_3,
   output logic [2:0]    stage,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   localparam logic [1:0]    M_NTT     = 2'b00;
   localparam logic [1:0]    M_INTT    = 2'b01;
   localparam logic [1:0]    M_PWM     = 2'b10;
   localparam logic [1:0]    M_ILL     = 2'b11;
   localparam int            SR_D      = 15;
   localparam logic [3:0]    LAT_BF_C  = 4'(LAT_BF);
   localparam logic [3:0]    LAT_PWM_C = 4'(LAT_PWM);
   localparam logic [AW-1:0] LAST_WORD = {AW{1'b1}};
   // Routing patterns packed as {sel_a_0, sel_a_1, sel_a_2, sel_a_3}
   localparam logic [7:0]    PAT_A     = 8'b01_11_00_10;
   localparam logic [7:0]    PAT_B     = 8'b01_00_11_10;
   localparam logic [7:0]    PAT_C     = 8'b00_01_10_11;

   state_t        state_q, state_d;
   logic [1:0]    mode_q, mode_d;
   logic [2:0]    stage_q, stage_d;
   logic [AW-1:0] wcnt_q, wcnt_d;
   logic [3:0]    dcnt_q, dcnt_d;
   logic [2:0]    net_sel_q, net_sel_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          sr_en_q [SR_D];
   logic          sr_en_d [SR_D];
   logic [AW-1:0] sr_addr_q [SR_D];
   logic [AW-1:0] sr_addr_d [SR_D];

   logic          stall_w;
   logic          rd_en_w;
   logic [3:0]    lat_w;
   logic [3:0]    tap_w;
   logic [2:0]    last_stage_w;
   logic [7:0]    sel_w;

`ifdef BF_NET_SCHED_STALL_EN
   assign stall_w = stall;
`else
   assign stall_w = 1'b0;
`endif

   // Network mode code for an accepted operation
   function automatic logic [2:0] net_code(input logic [1:0] m);
      logic [2:0] c;
      c = 3'b000;
      case (m)
         M_NTT:   c = 3'b001;
         M_INTT:  c = 3'b011;
         M_PWM:   c = 3'b010;
         default: c = 3'b000;
      endcase
      return c;
   endfunction

   // The latched mode picks both the drain length and the write-back tap,
   // so the two always agree for the operation in flight.
   assign lat_w        = (mode_q == M_PWM) ? LAT_PWM_C : LAT_BF_C;
   assign tap_w        = lat_w - 4'd1;
   assign last_stage_w = (mode_q == M_PWM) ? 3'd0 : 3'd6;
   assign rd_en_w      = (state_q == S_ISSUE) && !stall_w;

   // Sequencer next-state: accept/reject start, word issue, drain countdown, stage advance
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      stage_d   = stage_q;
      wcnt_d    = wcnt_q;
      dcnt_d    = dcnt_q;
      net_sel_d = net_sel_q;
      err_d     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (mode == M_ILL) begin
                  err_d = 1'b1;
               end else begin
                  mode_d    = mode;
                  stage_d   = 3'd0;
                  wcnt_d    = '0;
                  net_sel_d = net_code(mode);
                  state_d   = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (!stall_w) begin
               if (wcnt_q == LAST_WORD) begin
                  wcnt_d  = '0;
                  dcnt_d  = lat_w;
                  state_d = S_DRAIN;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (!stall_w) begin
               if (dcnt_q <= 4'd1) begin
                  dcnt_d = 4'd0;
                  if (stage_q < last_stage_w) begin
                     stage_d = stage_q + 3'd1;
                     wcnt_d  = '0;
                     state_d = S_ISSUE;
                  end else begin
                     state_d = S_DONE;
                  end
               end else begin
                  dcnt_d = dcnt_q - 4'd1;
               end
            end
         end
         S_DONE: begin
            stage_d   = 3'd0;
            net_sel_d = 3'b000;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // Write-back delay line: slot i holds the read strobe/address from i+1 cycles ago
   always_comb begin
      sr_en_d[0]   = rd_en_w;
      sr_addr_d[0] = wcnt_q;
      for (int i = 1; i < SR_D; i++) begin
         sr_en_d[i]   = sr_en_q[i-1];
         sr_addr_d[i] = sr_addr_q[i-1];
      end
   end

   // Lane routing pattern by mode and stage, forced to 00 on non-read cycles
   always_comb begin
      sel_w = 8'h00;
      if (rd_en_w) begin
         case (mode_q)
            M_NTT:   sel_w = (stage_q == 3'd6) ? PAT_B : PAT_A;
            M_INTT:  sel_w = (stage_q == 3'd0) ? PAT_B : PAT_A;
            default: sel_w = PAT_C;
         endcase
      end
   end

   // State and output registers; reset clears everything including pending write-backs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         mode_q    <= M_NTT;
         stage_q   <= 3'd0;
         wcnt_q    <= '0;
         dcnt_q    <= 4'd0;
         net_sel_q <= 3'b000;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         for (int i = 0; i < SR_D; i++) begin
            sr_en_q[i]   <= 1'b0;
            sr_addr_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         stage_q   <= stage_d;
         wcnt_q    <= wcnt_d;
         dcnt_q    <= dcnt_d;
         net_sel_q <= net_sel_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         for (int i = 0; i < SR_D; i++) begin
            sr_en_q[i]   <= sr_en_d[i];
            sr_addr_q[i] <= sr_addr_d[i];
         end
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;
   assign net_sel = net_sel_q;
   assign stage   = stage_q;
   assign rd_en   = rd_en_w;
   assign rd_addr = wcnt_q;
   assign wr_en   = sr_en_q[tap_w];
   assign wr_addr = sr_addr_q[tap_w];
   assign sel_a_0 = sel_w[7:6];
   assign sel_a_1 = sel_w[5:4];
   assign sel_a_2 = sel_w[3:2];
   assign sel_a_3 = sel_w[1:0];

endmodule

// File: tb/tb_bf_net_sched.sv
// Directed bench for bf_net_sched: NTT, INTT, PWM, illegal/busy start,
// mid-run reset, and (with BF_NET_SCHED_STALL_EN) an issue stall.
module tb_bf_net_sched;

   localparam int NCYC = 600;
   localparam logic [7:0] PAT_A = 8'h72;
   localparam logic [7:0] PAT_B = 8'h4E;
   localparam logic [7:0] PAT_C = 8'h1B;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [1:0] mode;
`ifdef BF_NET_SCHED_STALL_EN
   logic       stall;
   int         stall_from = -1;
   int         stall_to   = -2;
`endif
   logic       busy, done, err;
   logic [2:0] net_sel, stage;
   logic [1:0] sel_a_0, sel_a_1, sel_a_2, sel_a_3;
   logic       rd_en, wr_en;
   logic [5:0] rd_addr, wr_addr;

   logic [7:0]  sel_now;
   logic [30:0] all_outs;
   assign sel_now  = {sel_a_0, sel_a_1, sel_a_2, sel_a_3};
   assign all_outs = {busy, done, err, net_sel, stage, rd_en, rd_addr, wr_en, wr_addr, sel_now};

   bf_net_sched dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .mode    (mode),
`ifdef BF_NET_SCHED_STALL_EN
      .stall   (stall),
`endif
      .busy    (busy),
      .done    (done),
      .err     (err),
      .net_sel (net_sel),
      .sel_a_0 (sel_a_0),
      .sel_a_1 (sel_a_1),
      .sel_a_2 (sel_a_2),
      .sel_a_3 (sel_a_3),
      .stage   (stage),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .wr_en   (wr_en),
      .wr_addr (wr_addr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   logic       rd_en_log   [NCYC];
   logic [5:0] rd_addr_log [NCYC];
   logic       wr_en_log   [NCYC];
   logic [5:0] wr_addr_log [NCYC];
   logic [7:0] sel_log     [NCYC];
   logic [2:0] stage_log   [NCYC];
   logic [2:0] net_log     [NCYC];
   logic       busy_log    [NCYC];
   logic       done_log    [NCYC];
   logic       err_log     [NCYC];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic sample(input int c);
      rd_en_log[c]   = rd_en;
      rd_addr_log[c] = rd_addr;
      wr_en_log[c]   = wr_en;
      wr_addr_log[c] = wr_addr;
      sel_log[c]     = sel_now;
      stage_log[c]   = stage;
      net_log[c]     = net_sel;
      busy_log[c]    = busy;
      done_log[c]    = done;
      err_log[c]     = err;
   endtask

   // Cycle 0 is the start-accept cycle; the mode input is scrambled to 11
   // while the run is in flight, and start is re-pulsed at busy_start.
   task automatic run_op(input logic [1:0] m, input int busy_start);
      start = 1'b1;
      mode  = m;
      #1;
      sample(0);
      for (int c = 1; c < NCYC; c++) begin
         @(posedge clk);
         #1;
         start = (c == busy_start);
         mode  = 2'b11;
`ifdef BF_NET_SCHED_STALL_EN
         stall = (c >= stall_from) && (c <= stall_to);
`endif
         #1;
         sample(c);
      end
      start = 1'b0;
      mode  = 2'b00;
`ifdef BF_NET_SCHED_STALL_EN
      stall = 1'b0;
`endif
   endtask

   function automatic int first_done();
      for (int c = 0; c < NCYC; c++) if (done_log[c]) return c;
      return -1;
   endfunction

   function automatic int first_wr();
      for (int c = 0; c < NCYC; c++) if (wr_en_log[c]) return c;
      return -1;
   endfunction

   function automatic int count_rd();
      int n;
      n = 0;
      for (int c = 0; c < NCYC; c++) if (rd_en_log[c]) n++;
      return n;
   endfunction

   function automatic int count_err();
      int n;
      n = 0;
      for (int c = 0; c < NCYC; c++) if (err_log[c]) n++;
      return n;
   endfunction

   // Write-back must be the read side delayed by exactly lat cycles
   function automatic int wr_model_bad(input int lat);
      int   bad;
      logic e_en;
      bad = 0;
      for (int c = 0; c < NCYC; c++) begin
         e_en = (c >= lat) ? rd_en_log[c-lat] : 1'b0;
         if (wr_en_log[c] !== e_en) bad++;
         else if (e_en && (wr_addr_log[c] !== rd_addr_log[c-lat])) bad++;
      end
      return bad;
   endfunction

   function automatic int net_bad(input logic [2:0] code, input int last);
      int bad;
      bad = 0;
      for (int c = 1; c <= last && c < NCYC; c++) if (net_log[c] !== code) bad++;
      return bad;
   endfunction

   // First-stage reads: cycles 1..64 with address c-1
   function automatic int stage0_rd_bad();
      int bad;
      bad = 0;
      for (int c = 1; c <= 64; c++)
         if (!rd_en_log[c] || rd_addr_log[c] !== 6'(c - 1)) bad++;
      return bad;
   endfunction

   int wr_any;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      mode  = 2'b00;
`ifdef BF_NET_SCHED_STALL_EN
      stall = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #2;
      chk("reset_outputs", 32'(all_outs), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      chk("idle_after_reset", 32'(all_outs), 32'd0);

      // ---- NTT with a start re-pulse at cycle 30 ----
      run_op(2'b00, 30);
      chk("ntt_busy_c0", 32'(busy_log[0]), 32'd0);
      chk("ntt_rd_c0", 32'(rd_en_log[0]), 32'd0);
      chk("ntt_stage0_reads", 32'(stage0_rd_bad()), 32'd0);
      chk("ntt_rd_c65", 32'(rd_en_log[65]), 32'd0);
      chk("ntt_first_wr_cyc", 32'(first_wr()), 32'd8);
      chk("ntt_first_wr_addr", 32'(wr_addr_log[8]), 32'd0);
      chk("ntt_wr_model", 32'(wr_model_bad(7)), 32'd0);
      chk("ntt_sel_c1", 32'(sel_log[1]), 32'(PAT_A));
      chk("ntt_sel_drain", 32'(sel_log[66]), 32'd0);
      chk("ntt_stage_c427", 32'(stage_log[427]), 32'd6);
      chk("ntt_sel_c427", 32'(sel_log[427]), 32'(PAT_B));
      chk("ntt_sel_c426", 32'(sel_log[426]), 32'd0);
      chk("ntt_rd_total", 32'(count_rd()), 32'd448);
      chk("ntt_done_cyc", 32'(first_done()), 32'd498);
      chk("ntt_done_c499", 32'(done_log[499]), 32'd0);
      chk("ntt_busy_c498", 32'(busy_log[498]), 32'd1);
      chk("ntt_busy_c499", 32'(busy_log[499]), 32'd0);
      chk("ntt_net_sel", 32'(net_bad(3'b001, 498)), 32'd0);
      chk("ntt_net_idle", 32'(net_log[499]), 32'd0);
      chk("ntt_no_err", 32'(count_err()), 32'd0);

      // ---- INTT ----
      run_op(2'b01, -1);
      chk("intt_sel_s0", 32'(sel_log[1]), 32'(PAT_B));
      chk("intt_stage_c72", 32'(stage_log[72]), 32'd1);
      chk("intt_sel_s1", 32'(sel_log[72]), 32'(PAT_A));
      chk("intt_net_sel", 32'(net_bad(3'b011, 498)), 32'd0);
      chk("intt_done_cyc", 32'(first_done()), 32'd498);
      chk("intt_wr_model", 32'(wr_model_bad(7)), 32'd0);

      // ---- PWM ----
      run_op(2'b10, -1);
      chk("pwm_rd_total", 32'(count_rd()), 32'd64);
      chk("pwm_sel_c1", 32'(sel_log[1]), 32'(PAT_C));
      chk("pwm_sel_c64", 32'(sel_log[64]), 32'(PAT_C));
      chk("pwm_first_wr", 32'(first_wr()), 32'd11);
      chk("pwm_last_wr", 32'({wr_en_log[74], wr_addr_log[74]}), 32'({1'b1, 6'd63}));
      chk("pwm_wr_c75", 32'(wr_en_log[75]), 32'd0);
      chk("pwm_wr_model", 32'(wr_model_bad(10)), 32'd0);
      chk("pwm_done_cyc", 32'(first_done()), 32'd75);
      chk("pwm_stage", 32'({stage_log[1], stage_log[40], stage_log[70], stage_log[75]}), 32'd0);
      chk("pwm_net_sel", 32'(net_bad(3'b010, 75)), 32'd0);

      // ---- Illegal mode ----
      start = 1'b1;
      mode  = 2'b11;
      @(posedge clk);
      #2;
      start = 1'b0;
      mode  = 2'b00;
      chk("ill_err", 32'(err), 32'd1);
      chk("ill_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #2;
      chk("ill_err_pulse", 32'({err, busy, rd_en}), 32'd0);

      // ---- Reset mid-run at cycle 100 of NTT ----
      start = 1'b1;
      mode  = 2'b00;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk);
         #2;
         start = 1'b0;
      end
      chk("mid_pre_rd", 32'(rd_en), 32'd1);
      chk("mid_pre_wr", 32'(wr_en), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_outputs", 32'(all_outs), 32'd0);
      @(posedge clk);
      #2;
      rst_n  = 1'b1;
      wr_any = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #2;
         if (wr_en || rd_en || busy) wr_any++;
      end
      chk("mid_post_release_quiet", 32'(wr_any), 32'd0);

`ifdef BF_NET_SCHED_STALL_EN
      // ---- NTT with stall over cycles 10..14 ----
      stall_from = 10;
      stall_to   = 14;
      run_op(2'b00, -1);
      chk("stl_rd_c9", 32'({rd_en_log[9], rd_addr_log[9]}), 32'({1'b1, 6'd8}));
      chk("stl_hold_c10", 32'({rd_en_log[10], rd_addr_log[10], sel_log[10]}), 32'({1'b0, 6'd9, 8'd0}));
      chk("stl_hold_c14", 32'({rd_en_log[14], rd_addr_log[14]}), 32'({1'b0, 6'd9}));
      chk("stl_resume_c15", 32'({rd_en_log[15], rd_addr_log[15]}), 32'({1'b1, 6'd9}));
      chk("stl_wr_gap", 32'({wr_en_log[16], wr_en_log[17], wr_en_log[19], wr_en_log[21], wr_en_log[22]}),
          32'(5'b10001));
      chk("stl_wr_model", 32'(wr_model_bad(7)), 32'd0);
      chk("stl_done_cyc", 32'(first_done()), 32'd503);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/bf_net_sched.md
Name: bf_net_sched

Overview:
- Sequencer for the two-butterfly, four-lane coefficient datapath.
- Generates per-cycle coefficient read addresses, output-network mode and lane routing selects (sel_a_0..3), and the delayed write-back enables and addresses.
- Runs NTT (7 stages), INTT (7 stages) or pointwise multiply (PWM, 1 pass) over a 256-coefficient polynomial stored as 64 words of 4 coefficients.
- Sits between the top-level Kyber control FSM and the butterfly/network/RAM datapath.

Parameters:
- LAT_BF, 7, read-issue to write-back latency in cycles for NTT/INTT passes (1..15).
- LAT_PWM, 10, read-issue to write-back latency in cycles for PWM passes (1..15, LAT_PWM >= LAT_BF).
- AW, 6, word address width; words per stage = 2**AW.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request, sampled only in IDLE.
- mode  in  2  operation: 00 NTT, 01 INTT, 10 PWM, 11 illegal.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse when start is sampled with mode=11.
- net_sel  out  3  network mode: NTT 001, INTT 011, PWM 010, 000 when idle.
- sel_a_0, sel_a_1, sel_a_2, sel_a_3  out  2 each  lane routing codes, issued aligned with rd_en.
- stage  out  3  current stage index, 0..6.
- rd_en  out  1  coefficient word read strobe.
- rd_addr  out  AW  coefficient word read address.
- wr_en  out  1  write-back strobe.
- wr_addr  out  AW  write-back address.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0; latency shift register cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 with mode!=11: latch mode, set net_sel, enter ISSUE next cycle.
  - start=1 with mode=11: pulse err, stay in IDLE.
- ISSUE:
  - rd_en=1 each cycle; rd_addr = word counter, runs 0..2**AW-1.
  - After the last word, enter DRAIN with a drain counter = LAT (LAT_BF for NTT/INTT, LAT_PWM for PWM).
- DRAIN:
  - rd_en=0; lasts exactly LAT cycles, so the stage's final wr_en lands in the last DRAIN cycle.
  - Then, if stage < last stage (6 for NTT/INTT, 0 for PWM): stage+1, word counter 0, return to ISSUE.
  - Otherwise enter DONE.
- DONE: done=1 for one cycle, then IDLE; net_sel returns to 000 in IDLE.
- Write-back timing: wr_en and wr_addr equal rd_en and rd_addr delayed by exactly LAT cycles, via a shift register of depth 15 with a mode-selected tap.
- net_sel is held constant from the first ISSUE cycle through DONE.
- Routing patterns, listed as {sel_a_0, sel_a_1, sel_a_2, sel_a_3}:
  - A = {01, 11, 00, 10}
  - B = {01, 00, 11, 10}
  - C = {00, 01, 10, 11}
- Pattern by mode and stage:
  - NTT: stages 0..5 use A, stage 6 uses B.
  - INTT: stage 0 uses B, stages 1..6 use A.
  - PWM: C.
- sel_a_x = 00 whenever rd_en=0.
- start while busy is ignored; mode changes while busy are ignored.
- Word counter wraps only through the ISSUE-to-DRAIN transition; it never wraps inside a stage.
- Reset asserted mid-operation: immediate return to reset values; no pending wr_en is emitted after release.
- Total cycles from the start-accept cycle to the done pulse: 1 + stages*(2**AW + LAT).

Optional Feature:
- Macro: BF_NET_SCHED_STALL_EN.
- With the macro defined:
  - Adds input port stall (1 bit).
  - stall=1 in ISSUE: rd_en=0, sel_a_x=00, word counter holds. The latency shift register keeps advancing, so bubbles propagate to wr_en.
  - stall=1 in DRAIN: the drain counter holds.
  - stall is ignored in IDLE and DONE.
- Without the macro: no stall port; issue is never interrupted.

Test Plan:
- Reset then NTT: start=1, mode=00 at cycle 0 (defaults).
  - rd_en high cycles 1..64; first wr_en at cycle 8 with wr_addr=0.
  - stage=6 pattern B at cycle 427; done pulse at cycle 498.
  - net_sel=001 throughout, 000 after done.
- INTT: mode=01.
  - Stage 0 routing codes {01, 00, 11, 10}, stage 1 {01, 11, 00, 10}.
  - net_sel=011; done at cycle 498.
- PWM: mode=10.
  - 64 reads with codes {00, 01, 10, 11}; wr_en cycles 11..74; done at cycle 75; stage stays 0.
- Illegal and busy start:
  - start with mode=11 gives an err pulse, busy stays 0.
  - start pulsed at cycle 30 of an NTT run is ignored; done timing unchanged.
- Reset mid-run: deassert rst_n at cycle 100 of NTT.
  - All outputs 0 asynchronously.
  - After release, no wr_en for 20 cycles without a new start.
- With BF_NET_SCHED_STALL_EN, NTT with stall=1 during cycles 10..14:
  - rd_addr holds at 9; wr_en gap appears at cycles 17..21.
  - done shifts to cycle 503.
